// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer: countdown FSM owning HI/LO for the E stage.
// Define MDU_MADD_EN to accept madd/maddu/msub/msubu as MULT-class ops.
module mdu_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_valid,
  input  logic [3:0]  E_MDUOp,
  input  logic [31:0] E_V1,
  input  logic [31:0] E_V2,
  output logic        MDU_start,
  output logic        MDU_busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_DIV
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic        dz_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] phi_q, plo_q;

  logic        is_mul, is_div, sgn;
  logic        is_mthi, is_mtlo;
`ifdef MDU_MADD_EN
  logic        acc_add, acc_sub;
`endif

  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    sgn     = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
`ifdef MDU_MADD_EN
    acc_add = 1'b0;
    acc_sub = 1'b0;
`endif
    case (E_MDUOp)
      4'd1: begin is_mul = 1'b1; sgn = 1'b1; end
      4'd2: is_mul = 1'b1;
      4'd3: begin is_div = 1'b1; sgn = 1'b1; end
      4'd4: is_div = 1'b1;
      4'd5: is_mthi = 1'b1;
      4'd6: is_mtlo = 1'b1;
`ifdef MDU_MADD_EN
      4'd9:  begin is_mul = 1'b1; sgn = 1'b1; acc_add = 1'b1; end
      4'd10: begin is_mul = 1'b1; acc_add = 1'b1; end
      4'd11: begin is_mul = 1'b1; sgn = 1'b1; acc_sub = 1'b1; end
      4'd12: begin is_mul = 1'b1; acc_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Operands extended by signedness; the low 64 bits of the
  // 64x64 product are then correct for both mult and multu.
  logic [63:0] a64, b64, prod;
  assign a64  = {{32{sgn & E_V1[31]}}, E_V1};
  assign b64  = {{32{sgn & E_V2[31]}}, E_V2};
  assign prod = a64 * b64;

  logic        a_neg, b_neg;
  logic [31:0] ua, ub, ub_safe, uq, ur, q, r;
  assign a_neg   = sgn & E_V1[31];
  assign b_neg   = sgn & E_V2[31];
  assign ua      = a_neg ? -E_V1 : E_V1;
  assign ub      = b_neg ? -E_V2 : E_V2;
  assign ub_safe = (ub == 32'd0) ? 32'd1 : ub;
  assign uq      = ua / ub_safe;
  assign ur      = ua % ub_safe;
  assign q       = (a_neg ^ b_neg) ? -uq : uq;
  assign r       = a_neg ? -ur : ur;

  logic [63:0] res_d;
  always_comb begin
    res_d = is_div ? {r, q} : prod;
`ifdef MDU_MADD_EN
    if (acc_add) res_d = {hi_q, lo_q} + prod;
    if (acc_sub) res_d = {hi_q, lo_q} - prod;
`endif
  end

  assign MDU_start = E_valid && (state_q == S_IDLE)
                     && (is_mul || is_div);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (MDU_start) begin
            phi_q   <= res_d[63:32];
            plo_q   <= res_d[31:0];
            dz_q    <= is_div && (E_V2 == 32'd0);
            busy_q  <= 1'b1;
            cnt_q   <= is_div ? 4'(DIV_CYCLES)
                              : 4'(MULT_CYCLES);
            state_q <= is_div ? S_DIV : S_MULT;
          end else if (E_valid && is_mthi) begin
            hi_q <= E_V1;
          end else if (E_valid && is_mtlo) begin
            lo_q <= E_V1;
          end
        end
        default: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            if (!dz_q) begin
              hi_q <= phi_q;
              lo_q <= plo_q;
            end
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign MDU_busy = busy_q;
  assign HI       = hi_q;
  assign LO       = lo_q;

  always_comb begin
    case (E_MDUOp)
      4'd7:    MDU_out = hi_q;
      4'd8:    MDU_out = lo_q;
      default: MDU_out = 32'd0;
    endcase
  end

endmodule
